// File: rtl/ftm_lockstep_checker.sv
// Lockstep comparator for the Cevero core pair: shadow regfile, checkpoint PC, recovery sequencer, read-back slave.
// Define FTM_TIMEOUT_EN to add the recovery timeout that escalates to a timed core reset.
module ftm_lockstep_checker #(
    parameter logic [31:0] BootAddr     = 32'h80,
    parameter int unsigned RecovTimeout = 1024,
    parameter int unsigned ResetCycles  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    input  logic        valid_instr_exec_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,
    input  logic        done_i,
    output logic        recover_o,
    output logic        reset_o,
    output logic        recovering_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALT    = 3'd1,
`ifdef FTM_TIMEOUT_EN
        RESTORE = 3'd2,
        RESET   = 3'd3
`else
        RESTORE = 3'd2
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        recover_q, recover_d;
    logic        recovering_q, recovering_d;
    logic        reset_q, reset_d;
    logic        error_q, error_d;
    logic [15:0] mm_cnt_q, mm_cnt_d;
    logic [31:0] ckpt_q, ckpt_d;
    logic [31:0] shadow_q [32];
    logic [31:0] shadow_d [32];
    logic        rvalid_q, rvalid_d;
    logic        rerr_q, rerr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mismatch;
    logic        agreed_wr;
    logic [5:0]  word;
    logic        unused_ok;

`ifdef FTM_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign unused_ok = ^{data_be_i, data_wdata_i, data_addr_i[31:8], data_addr_i[1:0]};
    assign word      = data_addr_i[7:2];

    assign mismatch  = (state_q == IDLE) && enable_i &&
                       ((we_a_i != we_b_i) ||
                        (we_a_i && we_b_i && ((addr_a_i != addr_b_i) || (data_a_i != data_b_i))));
    assign agreed_wr = (state_q == IDLE) && we_a_i && we_b_i && (addr_a_i == addr_b_i) &&
                       (data_a_i == data_b_i) && (addr_a_i != 5'd0);

    // Slave response is computed from pre-edge state and presented one cycle after the grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rvalid_d = data_req_i;
        rerr_d   = 1'b0;
        rdata_d  = '0;
        if (data_req_i) begin
            if (data_we_i) begin
                rerr_d = 1'b1;
            end else if (!word[5]) begin
                rdata_d = shadow_q[word[4:0]];
            end else if (word == 6'd32) begin
                rdata_d = ckpt_q;
            end else if (word == 6'd33) begin
                rdata_d = {13'b0, state_q, mm_cnt_q};
            end else begin
                rerr_d = 1'b1;
            end
        end
    end

    always_comb begin
        mm_cnt_d = mm_cnt_q;
        error_d  = error_q;
        ckpt_d   = ckpt_q;
        shadow_d = shadow_q;
        if (mismatch) begin
            mm_cnt_d = (mm_cnt_q == 16'hFFFF) ? mm_cnt_q : mm_cnt_q + 16'd1;
            error_d  = 1'b1;
        end else begin
            if (agreed_wr) shadow_d[addr_a_i] = data_a_i;
            if ((state_q == IDLE) && valid_instr_exec_i) ckpt_d = pc_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (mismatch) state_d = HALT;
            HALT: begin
                if (done_i) state_d = IDLE;
`ifdef FTM_TIMEOUT_EN
                else if (tmo_cnt_q == 32'(RecovTimeout - 1)) state_d = RESET;
`endif
                else if (data_req_i) state_d = RESTORE;
            end
            RESTORE: begin
                if (done_i) state_d = IDLE;
`ifdef FTM_TIMEOUT_EN
                else if (tmo_cnt_q == 32'(RecovTimeout - 1)) state_d = RESET;
`endif
            end
`ifdef FTM_TIMEOUT_EN
            RESET: if (tmo_cnt_q == 32'(ResetCycles - 1)) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        recover_d    = (state_d == HALT);
        recovering_d = (state_d == HALT) || (state_d == RESTORE);
`ifdef FTM_TIMEOUT_EN
        reset_d      = (state_d == RESET);
        // One counter times both the recovery window (HALT+RESTORE) and the reset pulse.
        tmo_cnt_d    = tmo_cnt_q + 32'd1;
        if ((state_q == IDLE) || ((state_d == RESET) && (state_q != RESET))) tmo_cnt_d = '0;
`else
        reset_d      = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            recover_q    <= 1'b0;
            recovering_q <= 1'b0;
            reset_q      <= 1'b0;
            error_q      <= 1'b0;
            mm_cnt_q     <= '0;
            ckpt_q       <= BootAddr;
            rvalid_q     <= 1'b0;
            rerr_q       <= 1'b0;
            rdata_q      <= '0;
            // NOTE: the shadow file must read back as zero after reset, so it is built from resettable flops, not a RAM.
            for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
`ifdef FTM_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            recover_q    <= recover_d;
            recovering_q <= recovering_d;
            reset_q      <= reset_d;
            error_q      <= error_d;
            mm_cnt_q     <= mm_cnt_d;
            ckpt_q       <= ckpt_d;
            rvalid_q     <= rvalid_d;
            rerr_q       <= rerr_d;
            rdata_q      <= rdata_d;
            shadow_q     <= shadow_d;
`ifdef FTM_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign data_gnt_o    = data_req_i;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = rerr_q;
    assign data_rdata_o  = rdata_q;
    assign recover_o     = recover_q;
    assign recovering_o  = recovering_q;
    assign reset_o       = reset_q;
    assign error_o       = error_q;

endmodule
